// File: rtl/mant_mul_sched_pkg.sv
// mant_mul_pkg: shared types and default sizes for the mantissa multiplier
// scheduler.
//   state_t : scheduler FSM states (IDLE -> CALC -> SEND -> IDLE)
//   NREQ_DEF, MW_DEF, IDW_DEF : default requester count, mantissa width, ID width
//   id_t    : requester ID sized for the default configuration
package mant_mul_pkg;

    localparam int NREQ_DEF = 4;
    localparam int MW_DEF   = 24;
    localparam int IDW_DEF  = $clog2(NREQ_DEF);

    typedef logic [IDW_DEF-1:0] id_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

endpackage

// File: rtl/mant_mul_sched_if.sv
// mant_mul_sched_if: requester, multiplier and response signals of the
// mantissa multiplier scheduler.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b         : packed operands, slice i belongs to requester i
//   mul_a/mul_b/mul_p   : shared multiplier operands and combinational product
//   rsp_valid/rsp_ready : response handshake
//   rsp_data/rsp_id     : registered product and the requester that owns it
// Modports: slave = scheduler side, master = requesters/multiplier/consumer side.
interface mant_mul_sched_if
    import mant_mul_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int MW   = MW_DEF
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*MW-1:0] req_a;
    logic [NREQ*MW-1:0] req_b;
    logic [MW-1:0]      mul_a;
    logic [MW-1:0]      mul_b;
    logic [2*MW-1:0]    mul_p;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*MW-1:0]    rsp_data;
    logic [IDW-1:0]     rsp_id;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/mant_mul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in  NREQ  request vector
//   ptr       in  IDW   highest-priority index; search runs ptr upward, wrapping
//   grant     out NREQ  one-hot grant (all zero when nothing requests)
//   grant_idx out IDW   index of the granted bit (0 when nothing requests)
//   any_grant out 1     at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [IDW-1:0] idx;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mant_mul_sched.sv
// mant_mul_sched: round-robin scheduler sharing one combinational mantissa
// multiplier between NREQ requesters. One operation at a time:
// IDLE (accept) -> CALC (multiply) -> SEND (hold response until taken).
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset
//   bus   slave modport of mant_mul_sched_if (requests, multiplier, response)
//   busy  out  high whenever the FSM is not in IDLE
module mant_mul_sched
    import mant_mul_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int MW   = MW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mant_mul_sched_if.slave   bus,
    output logic              busy
);

    localparam int IDW = $clog2(NREQ);

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic            accept;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Next-state and request handshake. A grant only exists where req_valid
    // is set, so req_ready high always means a completed handshake.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = grant;
                if (any_grant) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: state_d = SEND;
            SEND: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. mul_a/mul_b are the operand registers themselves, so operand
    // changes on the requester side after accept never reach the multiplier.
    // NOTE: every datapath register is reset, including operands and product,
    // so an aborted operation leaves no stale value visible on any output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            id_q          <= '0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
        end else begin
            if (accept) begin
                bus.mul_a <= bus.req_a[grant_idx*MW +: MW];
                bus.mul_b <= bus.req_b[grant_idx*MW +: MW];
                id_q      <= grant_idx;
                ptr_q     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == CALC) begin
                bus.rsp_data  <= bus.mul_p;
                bus.rsp_id    <= id_q;
                bus.rsp_valid <= 1'b1;
            end
            if (state_q == SEND && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mant_mul_sched.sv
// tb_mant_mul_sched: self-checking bench for mant_mul_sched.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising (active) edge. The shared multiplier is a
// plain behavioural product on the interface.
module tb_mant_mul_sched;
    import mant_mul_pkg::*;

    localparam int NREQ = 4;
    localparam int MW   = 24;

    logic clk;
    logic rst_n;
    logic busy;

    int checks;
    int failures;

    mant_mul_sched_if #(.NREQ(NREQ), .MW(MW)) bus ();

    mant_mul_sched #(.NREQ(NREQ), .MW(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    // The existing unsigned mantissa multiplier.
    assign bus.mul_p = {{MW{1'b0}}, bus.mul_a} * {{MW{1'b0}}, bus.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        id_t             id;
        logic [MW-1:0]   a;
        logic [MW-1:0]   b;
        logic [2*MW-1:0] p;
    } vec_t;

    typedef struct {
        int              id;
        logic [2*MW-1:0] p;
    } rsp_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int id);
        logic [NREQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic set_ops(input int id, input logic [MW-1:0] a, input logic [MW-1:0] b);
        bus.req_a[id*MW +: MW] = a;
        bus.req_b[id*MW +: MW] = b;
    endtask

    // One isolated transaction from a single requester with rsp_ready high.
    // Must be entered with the scheduler idle.
    task automatic run_single(input int id, input logic [MW-1:0] a, input logic [MW-1:0] b,
                              input logic [2*MW-1:0] p);
        @(negedge clk);
        set_ops(id, a, b);
        bus.req_valid = oh(id);
        bus.rsp_ready = 1'b1;
        #1;
        check($sformatf("single%0d_ready", id), 64'(bus.req_ready), 64'(oh(id)));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("single_calc_busy",  64'(busy), 64'd1);
        check("single_calc_noval", 64'(bus.rsp_valid), 64'd0);
        check("single_calc_mula",  64'(bus.mul_a), 64'(a));
        check("single_calc_mulb",  64'(bus.mul_b), 64'(b));
        @(negedge clk);
        #1;
        check("single_send_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_send_data",  64'(bus.rsp_data), 64'(p));
        check("single_send_id",    64'(bus.rsp_id), 64'(id));
        @(negedge clk);
        #1;
        check("single_done_valid", 64'(bus.rsp_valid), 64'd0);
        check("single_done_busy",  64'(busy), 64'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        vecs[0] = '{id: 2'd1, a: 24'h800000, b: 24'h800000, p: 48'h4000_0000_0000};
        vecs[1] = '{id: 2'd3, a: 24'hFFFFFF, b: 24'hFFFFFF, p: 48'hFFFF_FE00_0001};
        vecs[2] = '{id: 2'd0, a: 24'h000000, b: 24'hABCDEF, p: 48'h0};
        vecs[3] = '{id: 2'd2, a: 24'hFFFFFF, b: 24'h000001, p: 48'h0000_00FF_FFFF};
        vecs[4] = '{id: 2'd1, a: 24'h123456, b: 24'h000010, p: 48'h0000_0123_4560};
        vecs[5] = '{id: 2'd3, a: 24'h000003, b: 24'h000005, p: 48'd15};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id), 64'd0);
        check("rst_mul_a",     64'(bus.mul_a), 64'd0);
        check("rst_mul_b",     64'(bus.mul_b), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters valid from ptr=0: strict rotation, one response per 3 cycles.
        begin
            int n;
            int last;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) set_ops(i, MW'(i + 3), MW'(256 + i));
            bus.req_valid = '1;
            bus.rsp_ready = 1'b1;
            n    = 0;
            last = 0;
            for (int c = 0; c < 40 && n < 6; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                if (bus.rsp_valid) begin
                    check("rot_id", 64'(bus.rsp_id), 64'(n % NREQ));
                    check("rot_data", 64'(bus.rsp_data), 64'((n % NREQ + 3) * (256 + n % NREQ)));
                    if (n > 0) check("rot_interval", 64'(c - last), 64'd3);
                    last = c;
                    n++;
                    if (n == 6) bus.req_valid = '0;
                end
            end
            check("rot_count", 64'(n), 64'd6);
            bus.req_valid = '0;
            @(negedge clk);
        end

        // Single-requester vectors, each granted regardless of ptr.
        for (int v = 0; v < 6; v++) run_single(int'(vecs[v].id), vecs[v].a, vecs[v].b, vecs[v].p);

        // Backpressure: response held 5 extra cycles, second request waits.
        @(negedge clk);
        set_ops(0, 24'h00ABCD, 24'h000100);
        set_ops(2, 24'h000011, 24'h000002);
        bus.req_valid = oh(0);
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_ready0", 64'(bus.req_ready), 64'(oh(0)));
        @(negedge clk);
        bus.req_valid = oh(2);
        #1;
        check("bp_calc_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        #1;
        check("bp_valid_rise", 64'(bus.rsp_valid), 64'd1);
        check("bp_data",       64'(bus.rsp_data), 64'h00AB_CD00);
        check("bp_id",         64'(bus.rsp_id), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_data",  64'(bus.rsp_data), 64'h00AB_CD00);
            check("bp_hold_id",    64'(bus.rsp_id), 64'd0);
            check("bp_hold_ready", 64'(bus.req_ready), 64'd0);
            check("bp_hold_busy",  64'(busy), 64'd1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 64'(bus.rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        check("bp_after_valid", 64'(bus.rsp_valid), 64'd0);
        check("bp_after_busy",  64'(busy), 64'd0);
        check("bp_after_ready", 64'(bus.req_ready), 64'(oh(2)));
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        check("bp_next_id",   64'(bus.rsp_id), 64'd2);
        check("bp_next_data", 64'(bus.rsp_data), 64'd34);
        @(negedge clk);

        // Reset during CALC: in-flight work discarded, ptr back to 0.
        @(negedge clk);
        set_ops(2, 24'h000100, 24'h000100);
        bus.req_valid = oh(2);
        #1;
        check("rstmid_ready2", 64'(bus.req_ready), 64'(oh(2)));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("rstmid_calc_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rstmid_rsp_data",  64'(bus.rsp_data), 64'd0);
        check("rstmid_rsp_id",    64'(bus.rsp_id), 64'd0);
        check("rstmid_mul_a",     64'(bus.mul_a), 64'd0);
        check("rstmid_mul_b",     64'(bus.mul_b), 64'd0);
        check("rstmid_busy",      64'(busy), 64'd0);
        check("rstmid_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ops(0, 24'h000006, 24'h000007);
        bus.req_valid = oh(0) | oh(2);
        #1;
        check("rstmid_ptr0_wins", 64'(bus.req_ready), 64'(oh(0)));
        @(negedge clk);
        bus.req_valid = oh(2);
        #1;
        check("rstmid_no_stale", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        check("rstmid_id0",   64'(bus.rsp_id), 64'd0);
        check("rstmid_data0", 64'(bus.rsp_data), 64'd42);
        @(negedge clk);
        #1;
        check("rstmid_then2", 64'(bus.req_ready), 64'(oh(2)));
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        check("rstmid_id2", 64'(bus.rsp_id), 64'd2);
        @(negedge clk);

        // Operand change after accept is ignored.
        @(negedge clk);
        set_ops(0, 24'd5, 24'd7);
        bus.req_valid = oh(0);
        #1;
        check("opchg_ready", 64'(bus.req_ready), 64'(oh(0)));
        @(negedge clk);
        bus.req_valid = '0;
        set_ops(0, 24'd9, 24'd7);
        #1;
        check("opchg_mula", 64'(bus.mul_a), 64'd5);
        @(negedge clk);
        #1;
        check("opchg_data", 64'(bus.rsp_data), 64'd35);
        @(negedge clk);

        // Randomized traffic against a transaction-level model.
        begin
            logic [MW-1:0]   pa[NREQ];
            logic [MW-1:0]   pb[NREQ];
            bit              pv[NREQ];
            rsp_t            q[$];
            rsp_t            r;
            int              mptr;
            int              outstanding;
            int              age;
            int              pick;
            logic [NREQ-1:0] vvec;
            logic [NREQ-1:0] exp_ready;
            bit              any_pending;

            // ptr is 1 after the last grant to requester 0.
            mptr        = 1;
            outstanding = 0;
            age         = 0;
            for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;

            for (int c = 0; c < 900; c++) begin
                @(negedge clk);
                for (int i = 0; i < NREQ; i++) begin
                    if (pv[i] && $urandom_range(15) == 0) begin
                        pv[i] = 1'b0;
                    end else if (!pv[i] && c < 700 && $urandom_range(3) == 0) begin
                        pv[i] = 1'b1;
                        pa[i] = MW'($urandom());
                        pb[i] = MW'($urandom());
                    end
                end
                vvec = '0;
                for (int i = 0; i < NREQ; i++) begin
                    vvec[i] = pv[i];
                    if (pv[i]) set_ops(i, pa[i], pb[i]);
                end
                bus.req_valid = vvec;
                bus.rsp_ready = ($urandom_range(3) != 0);
                #1;

                pick        = -1;
                any_pending = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (pick < 0 && pv[(mptr + k) % NREQ]) pick = (mptr + k) % NREQ;
                end
                if (pick >= 0) any_pending = 1'b1;
                exp_ready = (outstanding == 0 && any_pending) ? oh(pick) : '0;
                check("rnd_req_ready", 64'(bus.req_ready), 64'(exp_ready));
                check("rnd_busy", 64'(busy), 64'(outstanding != 0));
                check("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(outstanding != 0 && age >= 2));

                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (q.size() == 0) begin
                        check("rnd_unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        r = q.pop_front();
                        check("rnd_rsp_id",   64'(bus.rsp_id), 64'(r.id));
                        check("rnd_rsp_data", 64'(bus.rsp_data), 64'(r.p));
                    end
                    outstanding = 0;
                end
                if (outstanding == 0 && any_pending && (bus.req_ready & bus.req_valid) != '0) begin
                    r.id = pick;
                    r.p  = (2*MW)'(pa[pick]) * (2*MW)'(pb[pick]);
                    q.push_back(r);
                    pv[pick]    = 1'b0;
                    mptr        = (pick + 1) % NREQ;
                    outstanding = 1;
                    age         = 0;
                end
                age++;
                if (c >= 700 && outstanding == 0) begin
                    any_pending = 1'b0;
                    for (int i = 0; i < NREQ; i++) if (pv[i]) any_pending = 1'b1;
                    if (!any_pending) break;
                end
            end
            check("rnd_drain_outstanding", 64'(outstanding), 64'd0);
            check("rnd_drain_queue", 64'(q.size()), 64'd0);
            bus.req_valid = '0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
